// File: rtl/pc_stack_ctrl.sv
// pc_stack_ctrl: program counter plus a DEPTH-level rotating return stack for
// the fetch stage of a 4004-class core. The active stack level is the PC.
// Each clock it runs at most one decoder command. The priority order is
// ret > call > jump > inc. It also tracks nesting depth and reports full and
// empty status and call-overflow and return-underflow.
//
// Build option: define STACK_ERR_EN to block calls at full and returns at
// empty. In that build the error flags are sticky until err_clr. Without the
// macro the stack wraps like the original 4004, the error flags are one-cycle
// pulses and err_clr is ignored.
module pc_stack_ctrl #(
  parameter int ADDR_W = 12,
  parameter int PAGE_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     CLK,
  input  logic                     RES_N,
  input  logic                     cmd_inc,
  input  logic                     cmd_jump,
  input  logic                     cmd_call,
  input  logic                     cmd_ret,
  input  logic [1:0]               target_sel,
  input  logic [7:0]               opr0,
  input  logic [7:0]               opr1,
  input  logic [7:0]               rp,
  input  logic                     err_clr,
  output logic [ADDR_W-1:0]        pc,
  output logic [ADDR_W-1:0]        pc_plus_one,
  output logic [$clog2(DEPTH)-1:0] depth,
  output logic                     stk_full,
  output logic                     stk_empty,
  output logic                     stk_ovf,
  output logic                     stk_unf
);

  localparam int SP_W = $clog2(DEPTH);

  logic [ADDR_W-1:0]        stack_q [DEPTH];
  logic [SP_W-1:0]          sp_reg, sp_next, sp_inc, sp_dec;
  logic [SP_W-1:0]          depth_reg, depth_next;
  logic                     ovf_reg, ovf_next, unf_reg, unf_next;
  logic                     ovf_evt, unf_evt;
  logic                     cur_we, push_we;
  logic [ADDR_W-1:0]        cur_data;
  logic [ADDR_W-1:0]        target;
  logic [ADDR_W-PAGE_W-1:0] hi;
  logic                     is_full, is_empty;

  // Some operand bits are not used for every parameter set, and err_clr is
  // not used in the wrap build.
  logic unused_inputs;
  assign unused_inputs = ^{err_clr, opr0, opr1, rp};

  assign pc          = stack_q[sp_reg];
  assign pc_plus_one = pc + 1'b1;
  assign sp_inc      = sp_reg + 1'b1;
  assign sp_dec      = sp_reg - 1'b1;
  assign hi          = pc_plus_one[ADDR_W-1:PAGE_W];
  assign is_full     = (depth_reg == SP_W'(DEPTH - 1));
  assign is_empty    = (depth_reg == '0);

  assign depth     = depth_reg;
  assign stk_full  = is_full;
  assign stk_empty = is_empty;
  assign stk_ovf   = ovf_reg;
  assign stk_unf   = unf_reg;

  // Branch target. Short and register targets take the page of pc+1, so an
  // instruction that ends a page lands in the next page.
  always_comb begin
    target = pc;
    case (target_sel)
      2'b00:   target = {hi, opr1[PAGE_W-1:0]};
      2'b01:   target = {opr0[ADDR_W-PAGE_W-1:0], opr1[PAGE_W-1:0]};
      2'b10:   target = {hi, rp[PAGE_W-1:0]};
      default: target = pc;
    endcase
  end

  // Command decode. This works out the stack writes, the new sp and depth,
  // and the error events.
  always_comb begin
    sp_next    = sp_reg;
    depth_next = depth_reg;
    cur_we     = 1'b0;
    cur_data   = pc_plus_one;
    push_we    = 1'b0;
    ovf_evt    = 1'b0;
    unf_evt    = 1'b0;
    if (cmd_ret) begin
      if (is_empty) begin
        unf_evt = 1'b1;
`ifndef STACK_ERR_EN
        sp_next = sp_dec;
`endif
      end else begin
        sp_next    = sp_dec;
        depth_next = depth_reg - 1'b1;
      end
    end else if (cmd_call) begin
      if (is_full) begin
        ovf_evt = 1'b1;
`ifndef STACK_ERR_EN
        cur_we  = 1'b1;
        push_we = 1'b1;
        sp_next = sp_inc;
`endif
      end else begin
        cur_we     = 1'b1;
        push_we    = 1'b1;
        sp_next    = sp_inc;
        depth_next = depth_reg + 1'b1;
      end
    end else if (cmd_jump) begin
      cur_we   = 1'b1;
      cur_data = target;
    end else if (cmd_inc) begin
      cur_we   = 1'b1;
      cur_data = pc_plus_one;
    end
  end

  // Error flags. A new error always wins over err_clr in the same cycle.
  always_comb begin
`ifdef STACK_ERR_EN
    ovf_next = ovf_evt | (ovf_reg & ~err_clr);
    unf_next = unf_evt | (unf_reg & ~err_clr);
`else
    ovf_next = ovf_evt;
    unf_next = unf_evt;
`endif
  end

  // Control state register: stack pointer, depth and error flags.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      sp_reg    <= '0;
      depth_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      sp_reg    <= sp_next;
      depth_reg <= depth_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // One register per stack level. On a call the level above sp takes the
  // target and the current level takes the return address.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_level
    logic [ADDR_W-1:0] level_reg;

    // Level storage, written by the push or by the current-level update.
    always_ff @(posedge CLK or negedge RES_N) begin
      if (!RES_N) begin
        level_reg <= '0;
      end else if (push_we && (sp_inc == SP_W'(gi))) begin
        level_reg <= target;
      end else if (cur_we && (sp_reg == SP_W'(gi))) begin
        level_reg <= cur_data;
      end
    end

    assign stack_q[gi] = level_reg;
  end

endmodule
